// File: rtl/ucpd_bmc_rx.sv
// BMC line decoder for the UCPD receive path: recovers bits, flags EOP and interval errors.
// Optional macro UCPD_BMC_RX_GLITCH_FILTER_EN adds a 3-sample majority filter ahead of edge detection.
module ucpd_bmc_rx #(
   parameter int unsigned UI_CLKS     = 40,
   parameter int unsigned GLITCH_CLKS = 4,
   parameter int unsigned IDLE_CLKS   = 80,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned BITCNT_W    = 10
) (
   input  logic                ic_clk,
   input  logic                ic_rst,
   input  logic                rx_en,
   input  logic                cc_datai,
   output logic                bit_valid,
   output logic                bit_data,
   output logic                rx_active,
   output logic                eop,
   output logic                err,
   output logic [BITCNT_W-1:0] bit_cnt
);

   localparam logic [CNT_W-1:0] L_GLITCH    = CNT_W'(GLITCH_CLKS);
   localparam logic [CNT_W-1:0] L_SHORT_MAX = CNT_W'(3 * UI_CLKS / 4);
   localparam logic [CNT_W-1:0] L_LONG_MAX  = CNT_W'(5 * UI_CLKS / 4);
   localparam logic [CNT_W-1:0] L_IDLE_M1   = CNT_W'(IDLE_CLKS - 1);

   typedef enum logic [1:0] {S_IDLE, S_BOUND, S_HALF} state_t;
   typedef enum logic [1:0] {C_GLITCH, C_SHORT, C_LONG, C_OVER} cls_t;

   state_t r_state, w_state_nxt;
   cls_t   w_cls;

   logic                r_s1, r_s2, r_s3;
   logic                w_line, w_edge;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_bit_valid, r_bit_data, r_rx_active, r_eop, r_err;
   logic [BITCNT_W-1:0] r_bit_cnt;
   logic                w_emit, w_emit_data, w_err, w_eop, w_start;

`ifdef UCPD_BMC_RX_GLITCH_FILTER_EN
   logic r_h1, r_h2, r_flt;

   always_ff @(posedge ic_clk) begin
      if (ic_rst) begin
         r_h1  <= 1'b0;
         r_h2  <= 1'b0;
         r_flt <= 1'b0;
      end else begin
         r_h1  <= r_s2;
         r_h2  <= r_h1;
         r_flt <= (r_s2 & r_h1) | (r_s2 & r_h2) | (r_h1 & r_h2);
      end
   end

   assign w_line = r_flt;
`else
   assign w_line = r_s2;
`endif

   assign w_edge = w_line ^ r_s3;

   always_comb begin
      if (r_cnt < L_GLITCH)          w_cls = C_GLITCH;
      else if (r_cnt <= L_SHORT_MAX) w_cls = C_SHORT;
      else if (r_cnt <= L_LONG_MAX)  w_cls = C_LONG;
      else                           w_cls = C_OVER;
   end

   always_ff @(posedge ic_clk) begin
      if (ic_rst) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // An edge always wins over the idle timeout, so eop and err can never coincide.
   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_emit_data = 1'b0;
      w_err       = 1'b0;
      w_eop       = 1'b0;
      w_start     = 1'b0;
      if (!rx_en) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_edge) begin
                  w_state_nxt = S_BOUND;
                  w_start     = 1'b1;
               end
            end
            S_BOUND: begin
               if (w_edge) begin
                  if (w_cls == C_LONG)       w_emit = 1'b1;
                  else if (w_cls == C_SHORT) w_state_nxt = S_HALF;
                  else                       w_err = 1'b1;
               end else if (r_cnt == L_IDLE_M1) begin
                  w_eop       = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            S_HALF: begin
               if (w_edge) begin
                  w_state_nxt = S_BOUND;
                  if (w_cls == C_SHORT) begin
                     w_emit      = 1'b1;
                     w_emit_data = 1'b1;
                  end else begin
                     w_err = 1'b1;
                  end
               end else if (r_cnt == L_IDLE_M1) begin
                  w_eop       = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge ic_clk) begin
      if (ic_rst) begin
         r_s1        <= 1'b0;
         r_s2        <= 1'b0;
         r_s3        <= 1'b0;
         r_cnt       <= '0;
         r_bit_valid <= 1'b0;
         r_bit_data  <= 1'b0;
         r_rx_active <= 1'b0;
         r_eop       <= 1'b0;
         r_err       <= 1'b0;
         r_bit_cnt   <= '0;
      end else begin
         r_s1        <= cc_datai;
         r_s2        <= r_s1;
         r_s3        <= w_line;
         if (w_edge)              r_cnt <= '0;
         else if (r_cnt != '1)    r_cnt <= r_cnt + 1'b1;
         r_bit_valid <= w_emit;
         r_eop       <= w_eop;
         r_err       <= w_err;
         if (w_emit) r_bit_data <= w_emit_data;
         if (w_start)                           r_bit_cnt <= '0;
         else if (w_emit && (r_bit_cnt != '1))  r_bit_cnt <= r_bit_cnt + 1'b1;
         if (w_start)                r_rx_active <= 1'b1;
         else if (w_eop || !rx_en)   r_rx_active <= 1'b0;
      end
   end

   assign bit_valid = r_bit_valid;
   assign bit_data  = r_bit_data;
   assign rx_active = r_rx_active;
   assign eop       = r_eop;
   assign err       = r_err;
   assign bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_ucpd_bmc_rx.sv
// Scoreboard bench for ucpd_bmc_rx: expected bits queued at stimulus time, compared against decoded bits.
module tb_ucpd_bmc_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_en = 1'b0;
   logic       cc = 1'b0;
   logic       bit_valid, bit_data, rx_active, eop, err;
   logic [9:0] bit_cnt;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   bit exp_q[$];
   bit obs_bits[$];
   int rd_idx = 0;
   int n_err = 0, n_eop = 0, n_both = 0;
   int last_bv_cyc = 0, eop_cyc = 0;

   ucpd_bmc_rx #(
      .UI_CLKS(40), .GLITCH_CLKS(4), .IDLE_CLKS(80), .CNT_W(8), .BITCNT_W(10)
   ) dut (
      .ic_clk(clk), .ic_rst(rst), .rx_en(rx_en), .cc_datai(cc),
      .bit_valid(bit_valid), .bit_data(bit_data), .rx_active(rx_active),
      .eop(eop), .err(err), .bit_cnt(bit_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bit_valid) begin
         obs_bits.push_back(bit_data);
         last_bv_cyc = cyc;
      end
      if (err) n_err = n_err + 1;
      if (eop) begin
         n_eop   = n_eop + 1;
         eop_cyc = cyc;
      end
      if (err && eop) n_both = n_both + 1;
   end

   task automatic toggle_after(input int n);
      repeat (n) @(posedge clk);
      #1 cc = ~cc;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(3);
      checks++; if (bit_valid !== 1'b0) begin failures++; $display("FAIL reset_bit_valid got %b want 0", bit_valid); end
      checks++; if (bit_data  !== 1'b0) begin failures++; $display("FAIL reset_bit_data got %b want 0", bit_data); end
      checks++; if (rx_active !== 1'b0) begin failures++; $display("FAIL reset_rx_active got %b want 0", rx_active); end
      checks++; if (eop       !== 1'b0) begin failures++; $display("FAIL reset_eop got %b want 0", eop); end
      checks++; if (err       !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (bit_cnt   !== 10'd0) begin failures++; $display("FAIL reset_bit_cnt got %0d want 0", bit_cnt); end
      @(posedge clk); #1 rst = 1'b0; rx_en = 1'b1;
      idle(5);
   endtask

   task automatic test_decode;
      int e0;
      bit e;
      e0 = n_err;
      toggle_after(5);
      toggle_after(40); exp_q.push_back(1'b0);
      toggle_after(20); toggle_after(20); exp_q.push_back(1'b1);
      toggle_after(20); toggle_after(20); exp_q.push_back(1'b1);
      toggle_after(40); exp_q.push_back(1'b0);
      idle(10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rd_idx >= obs_bits.size()) begin failures++; $display("FAIL decode_bit missing, want %b", e); end
         else begin
            if (obs_bits[rd_idx] !== e) begin failures++; $display("FAIL decode_bit[%0d] got %b want %b", rd_idx, obs_bits[rd_idx], e); end
            rd_idx++;
         end
      end
      checks++; if (obs_bits.size() != rd_idx) begin failures++; $display("FAIL decode_extra got %0d bits want %0d", obs_bits.size(), rd_idx); end
      rd_idx = obs_bits.size();
      checks++; if (bit_cnt !== 10'd4) begin failures++; $display("FAIL decode_bit_cnt got %0d want 4", bit_cnt); end
      checks++; if (n_err != e0) begin failures++; $display("FAIL decode_err got %0d pulses want 0", n_err - e0); end
      checks++; if (rx_active !== 1'b1) begin failures++; $display("FAIL decode_rx_active got %b want 1", rx_active); end
   endtask

   task automatic test_eop;
      int p0;
      p0 = n_eop;
      idle(100);
      checks++; if (n_eop != p0 + 1) begin failures++; $display("FAIL eop_count got %0d want 1", n_eop - p0); end
      checks++; if (eop_cyc - last_bv_cyc != 80) begin failures++; $display("FAIL eop_timing got %0d want 80", eop_cyc - last_bv_cyc); end
      checks++; if (rx_active !== 1'b0) begin failures++; $display("FAIL eop_rx_active got %b want 0", rx_active); end
   endtask

   task automatic test_glitch;
      int e0;
      bit e;
      e0 = n_err;
      toggle_after(10);
      toggle_after(3);
      toggle_after(40); exp_q.push_back(1'b0);
      idle(10);
      checks++; if (n_err != e0 + 1) begin failures++; $display("FAIL glitch_err got %0d pulses want 1", n_err - e0); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rd_idx >= obs_bits.size()) begin failures++; $display("FAIL glitch_bit missing, want %b", e); end
         else begin
            if (obs_bits[rd_idx] !== e) begin failures++; $display("FAIL glitch_bit got %b want %b", obs_bits[rd_idx], e); end
            rd_idx++;
         end
      end
      checks++; if (obs_bits.size() != rd_idx) begin failures++; $display("FAIL glitch_extra got %0d bits want %0d", obs_bits.size(), rd_idx); end
      rd_idx = obs_bits.size();
      checks++; if (bit_cnt !== 10'd1) begin failures++; $display("FAIL glitch_bit_cnt got %0d want 1", bit_cnt); end
   endtask

   task automatic test_half_long;
      int e0;
      bit e;
      e0 = n_err;
      toggle_after(20);
      toggle_after(40);
      toggle_after(20); toggle_after(20); exp_q.push_back(1'b1);
      idle(10);
      checks++; if (n_err != e0 + 1) begin failures++; $display("FAIL half_long_err got %0d pulses want 1", n_err - e0); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rd_idx >= obs_bits.size()) begin failures++; $display("FAIL half_long_bit missing, want %b", e); end
         else begin
            if (obs_bits[rd_idx] !== e) begin failures++; $display("FAIL half_long_bit got %b want %b", obs_bits[rd_idx], e); end
            rd_idx++;
         end
      end
      checks++; if (obs_bits.size() != rd_idx) begin failures++; $display("FAIL half_long_extra got %0d bits want %0d", obs_bits.size(), rd_idx); end
      rd_idx = obs_bits.size();
      checks++; if (bit_cnt !== 10'd2) begin failures++; $display("FAIL half_long_bit_cnt got %0d want 2", bit_cnt); end
      idle(100);
   endtask

   task automatic test_rx_en_drop;
      int p0, e0;
      bit e;
      toggle_after(10);
      repeat (3) begin toggle_after(40); exp_q.push_back(1'b0); end
      idle(10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rd_idx >= obs_bits.size()) begin failures++; $display("FAIL rx_en_bit missing, want %b", e); end
         else begin
            if (obs_bits[rd_idx] !== e) begin failures++; $display("FAIL rx_en_bit got %b want %b", obs_bits[rd_idx], e); end
            rd_idx++;
         end
      end
      checks++; if (rx_active !== 1'b1) begin failures++; $display("FAIL rx_en_active_before got %b want 1", rx_active); end
      p0 = n_eop; e0 = n_err;
      @(posedge clk); #1 rx_en = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++; if (rx_active !== 1'b0) begin failures++; $display("FAIL rx_en_active_after got %b want 0", rx_active); end
      toggle_after(20); toggle_after(20); toggle_after(40); toggle_after(3);
      idle(100);
      checks++; if (obs_bits.size() != rd_idx) begin failures++; $display("FAIL rx_en_ignored got %0d bits want %0d", obs_bits.size(), rd_idx); end
      rd_idx = obs_bits.size();
      checks++; if (n_eop != p0) begin failures++; $display("FAIL rx_en_eop got %0d pulses want 0", n_eop - p0); end
      checks++; if (n_err != e0) begin failures++; $display("FAIL rx_en_err got %0d pulses want 0", n_err - e0); end
      checks++; if (bit_cnt !== 10'd3) begin failures++; $display("FAIL rx_en_bit_cnt got %0d want 3", bit_cnt); end
      @(posedge clk); #1 rx_en = 1'b1;
      idle(5);
      checks++; if (rx_active !== 1'b0) begin failures++; $display("FAIL rx_en_reenable_active got %b want 0", rx_active); end
   endtask

   task automatic test_reset_mid;
      int p0, e0;
      bit e;
      toggle_after(10);
      toggle_after(40); exp_q.push_back(1'b0);
      toggle_after(20);
      idle(10);
      checks++; if (bit_cnt !== 10'd1) begin failures++; $display("FAIL rst_mid_bit_cnt_before got %0d want 1", bit_cnt); end
      p0 = n_eop; e0 = n_err;
      @(posedge clk); #1 rst = 1'b1; cc = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++; if ({bit_valid, bit_data, rx_active, eop, err} !== 5'b0) begin failures++; $display("FAIL rst_mid_outputs got %b want 00000", {bit_valid, bit_data, rx_active, eop, err}); end
      checks++; if (bit_cnt !== 10'd0) begin failures++; $display("FAIL rst_mid_bit_cnt got %0d want 0", bit_cnt); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(100);
      checks++; if (n_eop != p0 || n_err != e0) begin failures++; $display("FAIL rst_mid_pulses got eop=%0d err=%0d want 0 0", n_eop - p0, n_err - e0); end
      toggle_after(10);
      idle(10);
      checks++; if (rx_active !== 1'b1) begin failures++; $display("FAIL rst_mid_first_edge_active got %b want 1", rx_active); end
      checks++; if (obs_bits.size() != rd_idx + 1) begin failures++; $display("FAIL rst_mid_first_edge_bits got %0d want %0d", obs_bits.size(), rd_idx + 1); end
      toggle_after(40); exp_q.push_back(1'b0);
      idle(10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rd_idx >= obs_bits.size()) begin failures++; $display("FAIL rst_mid_bit missing, want %b", e); end
         else begin
            if (obs_bits[rd_idx] !== e) begin failures++; $display("FAIL rst_mid_bit got %b want %b", obs_bits[rd_idx], e); end
            rd_idx++;
         end
      end
      checks++; if (obs_bits.size() != rd_idx) begin failures++; $display("FAIL rst_mid_extra got %0d bits want %0d", obs_bits.size(), rd_idx); end
      checks++; if (bit_cnt !== 10'd1) begin failures++; $display("FAIL rst_mid_bit_cnt_after got %0d want 1", bit_cnt); end
      idle(100);
      checks++; if (n_both != 0) begin failures++; $display("FAIL eop_err_overlap got %0d want 0", n_both); end
   endtask

   initial begin
      test_reset;
      test_decode;
      test_eop;
      test_glitch;
      test_half_long;
      test_rx_en_drop;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got no completion want finish");
      $fatal(1);
   end

endmodule
